// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM state encoding and access-size helper
// for the data-memory responder.
`default_nettype none

package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_bytes = 4'd1;
            2'b01:   size_bytes = 4'd2;
            2'b10:   size_bytes = 4'd4;
            default: size_bytes = 4'd8;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
// load_extend: shifts the addressed lanes of a 64-bit word down to bit 0 and
// sign/zero-extends them according to the load funct3.
`default_nettype none

module load_extend
    import dmem_pkg::*;
(
    input  logic [63:0] word,
    input  logic [2:0]  lane,
    input  logic [2:0]  funct3,
    output logic [63:0] data
);

    logic [63:0] shifted;

    always_comb begin
        shifted = word >> {lane, 3'b000};
        case (funct3)
            F3_B:    data = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    data = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    data = {{32{shifted[31]}}, shifted[31:0]};
            F3_D:    data = shifted;
            F3_BU:   data = {56'd0, shifted[7:0]};
            F3_HU:   data = {48'd0, shifted[15:0]};
            F3_WU:   data = {32'd0, shifted[31:0]};
            default: data = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// dmem_responder: handshaked multi-cycle data memory (DEPTH x 64 bit) serving
// RV64 byte/half/word/double loads and stores with error reporting.
`default_nettype none

module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [63:0] mem [DEPTH];

    state_t      state, nxt;
    logic [3:0]  cnt;
    logic        commit;

    logic        cap_write;
    logic [2:0]  cap_funct3;
    logic [63:0] cap_addr;
    logic [63:0] cap_wdata;

    logic        acc_write;
    logic [2:0]  acc_funct3;
    logic [63:0] acc_addr;
    logic [63:0] acc_wdata;
    logic [3:0]  acc_size;
    logic [2:0]  lane;
    logic [AW-1:0] idx;
    logic        illegal, misaligned, out_of_range, acc_err;
    logic [15:0] lane_mask;
    logic [7:0]  byte_en;
    logic [63:0] old_word, wshift, merged, load_data;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_comb begin
        nxt    = state;
        commit = 1'b0;
        case (state)
            IDLE: if (req_valid) begin
                commit = (LATENCY == 1);
                nxt    = (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT: if (cnt == 4'd1) begin
                commit = 1'b1;
                nxt    = RESP;
            end
            RESP: if (rsp_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // With LATENCY==1 the access happens on the acceptance edge itself, so the
    // live request is used before it lands in the capture registers.
    always_comb begin
        if (state == IDLE) begin
            acc_write  = req_write;
            acc_funct3 = req_funct3;
            acc_addr   = req_addr;
            acc_wdata  = req_wdata;
        end else begin
            acc_write  = cap_write;
            acc_funct3 = cap_funct3;
            acc_addr   = cap_addr;
            acc_wdata  = cap_wdata;
        end
    end

    always_comb begin
        acc_size = size_bytes(acc_funct3);
        lane     = acc_addr[2:0];
        idx      = acc_addr[3 +: AW];
        illegal  = (acc_funct3 == 3'b111) || (acc_write && acc_funct3[2]);
        case (acc_funct3[1:0])
            2'b01:   misaligned = acc_addr[0];
            2'b10:   misaligned = |acc_addr[1:0];
            2'b11:   misaligned = |acc_addr[2:0];
            default: misaligned = 1'b0;
        endcase
        out_of_range = (acc_addr[63:3] >= 61'(DEPTH));
        acc_err      = illegal || misaligned || out_of_range;

        old_word  = out_of_range ? '0 : mem[idx];
        lane_mask = ((16'd1 << acc_size) - 16'd1) << lane;
        byte_en   = lane_mask[7:0];
        wshift    = acc_wdata << {lane, 3'b000};
        for (int b = 0; b < 8; b++) begin
            merged[8*b +: 8] = byte_en[b] ? wshift[8*b +: 8] : old_word[8*b +: 8];
        end
    end

    load_extend u_load_extend (
        .word   (old_word),
        .lane   (lane),
        .funct3 (acc_funct3),
        .data   (load_data)
    );

    // The array write sits in the reset-gated branch so an asserted reset can
    // never let an uncommitted store reach memory; the array itself is not reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_write  <= 1'b0;
            cap_funct3 <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= nxt;
            if (state == IDLE && req_valid) begin
                cap_write  <= req_write;
                cap_funct3 <= req_funct3;
                cap_addr   <= req_addr;
                cap_wdata  <= req_wdata;
                cnt        <= CNT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end

            if (commit) begin
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || acc_write) ? '0 : load_data;
                if (!acc_err && acc_write) mem[idx] <= merged;
            end else if (state == RESP && rsp_ready) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plus randomized checks of dmem_responder against
// a byte-addressed reference memory model.
`default_nettype none

module tb_dmem_responder;

    localparam int DEPTH   = 64;
    localparam int LATENCY = 2;
    localparam int NBYTES  = 8 * DEPTH;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;
    bit intrude = 1'b0;
    logic [7:0] model_mem [NBYTES];

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed little-endian memory with RV64 load/store rules.
    task automatic model_access(input bit wr, input logic [2:0] f3, input logic [63:0] a,
                                input logic [63:0] wd, output logic [63:0] d, output bit e);
        int sz;
        int base;
        logic [63:0] v;
        sz = 1 << f3[1:0];
        e = (f3 == 3'b111) || (wr && f3[2]) || ((a % 64'(sz)) != 0) || (a >= 64'(NBYTES));
        d = '0;
        if (!e) begin
            base = int'(a[31:0]);
            if (wr) begin
                for (int i = 0; i < sz; i++) model_mem[base + i] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < sz; i++) v = v | (64'(model_mem[base + i]) << (8 * i));
                if (!f3[2] && sz < 8 && v[8*sz - 1]) v = v | (~64'd0 << (8 * sz));
                d = v;
            end
        end
    endtask

    task automatic access(input bit wr, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, input int hold, input string tag,
                          output logic [63:0] got_d, output logic got_e);
        logic [63:0] exp_d;
        bit exp_e;
        int k;
        model_access(wr, f3, a, wd, exp_d, exp_e);
        @(negedge clk);
        check({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        rsp_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 1;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, 64'(k), 64'(LATENCY));
        got_d = rsp_rdata;
        got_e = rsp_err;
        check({tag, " rdata"}, rsp_rdata, exp_d);
        check({tag, " err"}, 64'(rsp_err), 64'(exp_e));
        check({tag, " req_ready busy"}, 64'(req_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            if (intrude) begin
                req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
                req_addr = 64'h30; req_wdata = 64'h5A;
            end
            @(negedge clk);
            check({tag, " hold valid"}, 64'(rsp_valid), 64'd1);
            check({tag, " hold rdata"}, rsp_rdata, exp_d);
            check({tag, " hold req_ready"}, 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, " post valid"}, 64'(rsp_valid), 64'd0);
        check({tag, " post rdata"}, rsp_rdata, 64'd0);
        check({tag, " post err"}, 64'(rsp_err), 64'd0);
        check({tag, " post req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] gd;
        logic        ge;
        logic [63:0] ra, rm, rw;
        logic [2:0]  rf;
        bit          rwr;

        for (int i = 0; i < NBYTES; i++) model_mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("reset req_ready", 64'(req_ready), 64'd1);
        check("reset rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset rsp_rdata", rsp_rdata, 64'd0);
        reset = 1'b1;

        access(1'b1, 3'b011, 64'h10, 64'h1122334455667788, 0, "sd10", gd, ge);
        check("sd10 err const", 64'(ge), 64'd0);
        access(1'b0, 3'b011, 64'h10, 64'd0, 0, "ld10", gd, ge);
        check("ld10 const", gd, 64'h1122334455667788);

        access(1'b1, 3'b000, 64'h13, 64'h80, 0, "sb13", gd, ge);
        access(1'b0, 3'b000, 64'h13, 64'd0, 0, "lb13", gd, ge);
        check("lb13 const", gd, 64'hFFFFFFFFFFFFFF80);
        access(1'b0, 3'b100, 64'h13, 64'd0, 0, "lbu13", gd, ge);
        check("lbu13 const", gd, 64'h80);
        access(1'b0, 3'b011, 64'h10, 64'd0, 0, "ld10b", gd, ge);
        check("ld10b const", gd, 64'h1122334480667788);

        access(1'b1, 3'b010, 64'h14, 64'hDEADBEEF, 0, "sw14", gd, ge);
        access(1'b0, 3'b010, 64'h14, 64'd0, 0, "lw14", gd, ge);
        check("lw14 const", gd, 64'hFFFFFFFFDEADBEEF);
        access(1'b0, 3'b110, 64'h14, 64'd0, 0, "lwu14", gd, ge);
        check("lwu14 const", gd, 64'h00000000DEADBEEF);
        access(1'b0, 3'b101, 64'h16, 64'd0, 0, "lhu16", gd, ge);
        check("lhu16 const", gd, 64'hDEAD);

        access(1'b0, 3'b001, 64'h11, 64'd0, 0, "lh11", gd, ge);
        check("lh11 err const", 64'(ge), 64'd1);
        check("lh11 rdata const", gd, 64'd0);
        access(1'b1, 3'b011, 64'h0C, 64'hFFFF_FFFF_FFFF_FFFF, 0, "sd0C", gd, ge);
        check("sd0C err const", 64'(ge), 64'd1);
        access(1'b0, 3'b011, 64'h08, 64'd0, 0, "ld08", gd, ge);
        check("ld08 const", gd, 64'd0);
        access(1'b0, 3'b011, 64'(NBYTES), 64'd0, 0, "ld_oob", gd, ge);
        check("ld_oob err const", 64'(ge), 64'd1);
        access(1'b1, 3'b100, 64'h18, 64'h77, 0, "sbu_illegal", gd, ge);
        check("sbu_illegal err const", 64'(ge), 64'd1);

        intrude = 1'b1;
        access(1'b0, 3'b011, 64'h10, 64'd0, 5, "backpressure", gd, ge);
        intrude = 1'b0;
        access(1'b0, 3'b000, 64'h30, 64'd0, 0, "lb30", gd, ge);
        check("lb30 const", gd, 64'd0);

        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b011;
        req_addr = 64'h20; req_wdata = 64'hAAAAAAAAAAAAAAAA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("midop busy", 64'(req_ready), 64'd0);
        reset = 1'b0;
        #1;
        check("midop req_ready", 64'(req_ready), 64'd1);
        check("midop rsp_valid", 64'(rsp_valid), 64'd0);
        check("midop rsp_rdata", rsp_rdata, 64'd0);
        check("midop rsp_err", 64'(rsp_err), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        access(1'b0, 3'b011, 64'h20, 64'd0, 0, "ld20", gd, ge);
        check("ld20 const", gd, 64'd0);

        for (int n = 0; n < 60; n++) begin
            rf  = 3'($urandom_range(0, 7));
            rwr = 1'($urandom_range(0, 1));
            ra  = 64'($urandom_range(0, NBYTES + 15));
            rm  = (64'd1 << rf[1:0]) - 64'd1;
            if ($urandom_range(0, 3) != 0) ra = ra & ~rm;
            rw  = {$urandom, $urandom};
            access(rwr, rf, ra, rw, int'($urandom_range(0, 2)), "rand", gd, ge);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
